// File: rtl/e203_flush_pkg.sv
// Shared types and helpers for the EXU commit/flush controller.
package e203_flush_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } flush_state_e;

    localparam int NCH_MAX = 8;

    function automatic int src_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int cnt_width(input int nch);
        return (nch > 1) ? $clog2(nch + 1) : 1;
    endfunction

    function automatic logic [3:0] popcount8(input logic [NCH_MAX-1:0] vec);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < NCH_MAX; i++) begin
            cnt = cnt + {3'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/e203_exu_flush_ctrl_chk.sv
// Protocol properties for the flush controller: request only in REQ, operands stable until ack.
module e203_exu_flush_ctrl_chk
    import e203_flush_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int SRC_W = 1
) (
    input logic             clk,
    input logic             rst,
    input flush_state_e     state,
    input logic             req,
    input logic             ack,
    input logic [PC_W-1:0]  op1,
    input logic [PC_W-1:0]  op2,
    input logic [SRC_W-1:0] src
);

    a_req_in_req_state: assert property (@(posedge clk) disable iff (rst)
        req |-> (state == ST_REQ));

    a_ops_stable: assert property (@(posedge clk) disable iff (rst)
        (req && !ack) |=> ($stable(op1) && $stable(op2) && $stable(src)));

endmodule

// File: rtl/e203_exu_flush_prio.sv
// Oldest-first (lowest index) request finder; mask covers every channel up to and including the hit.
module e203_exu_flush_prio
    import e203_flush_pkg::*;
#(
    parameter int  NCH   = 2,
    localparam int SRC_W = src_width(NCH)
) (
    input  logic [NCH-1:0]   req,
    output logic             hit,
    output logic [SRC_W-1:0] idx,
    output logic [NCH-1:0]   mask
);

    // Scan oldest to youngest; with no hit the mask stays all ones.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        mask = '0;
        for (int i = 0; i < NCH; i++) begin
            mask[i] = ~hit;
            if (req[i] && !hit) begin
                idx = SRC_W'(i);
            end else begin
                idx = idx;
            end
            hit = hit | req[i];
        end
    end

endmodule

// File: rtl/e203_exu_flush_ctrl.sv
// EXU commit/flush controller: oldest-flush pick, flush request hold, quiet gap, instret.
// Optional E203_FLUSH_PC_EN adds a registered pipe_flush_pc = op1 + op2 output.
module e203_exu_flush_ctrl
    import e203_flush_pkg::*;
#(
    parameter int  NCH       = 2,
    parameter int  PC_W      = 32,
    parameter int  CNT_W     = 64,
    parameter int  FLUSH_GAP = 1,
    localparam int SRC_W     = src_width(NCH),
    localparam int NCC_W     = cnt_width(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    cmt_i_valid,
    output logic [NCH-1:0]    cmt_i_ready,
    input  logic [NCH-1:0]    cmt_i_flush,
    input  logic [NCH-1:0]    cmt_i_retire,
    input  logic [NCH*PC_W-1:0] cmt_i_op1,
    input  logic [NCH*PC_W-1:0] cmt_i_op2,
    output logic              pipe_flush_req,
    input  logic              pipe_flush_ack,
    output logic [PC_W-1:0]   pipe_flush_add_op1,
    output logic [PC_W-1:0]   pipe_flush_add_op2,
    output logic [SRC_W-1:0]  pipe_flush_src,
    output logic              flush_pulse,
    output logic [NCC_W-1:0]  nonflush_cmt_cnt,
    output logic [CNT_W-1:0]  instret_cnt,
    output logic              busy
`ifdef E203_FLUSH_PC_EN
    ,
    output logic [PC_W-1:0]   pipe_flush_pc
`endif
);

    localparam int GAP_W = (FLUSH_GAP > 1) ? $clog2(FLUSH_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (FLUSH_GAP > 0) ? GAP_W'(FLUSH_GAP - 1) : '0;

    flush_state_e      state_r;
    logic              req_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [PC_W-1:0]   op1_r;
    logic [PC_W-1:0]   op2_r;
    logic [SRC_W-1:0]  src_r;
    logic [CNT_W-1:0]  instret_r;

    logic              win_hit_s;
    logic [SRC_W-1:0]  win_idx_s;
    logic [NCH-1:0]    win_mask_s;
    logic [NCH-1:0]    ready_s;
    logic [NCH-1:0]    acc_s;
    logic [PC_W-1:0]   win_op1_s;
    logic [PC_W-1:0]   win_op2_s;
    logic [3:0]        nonflush_pc_s;
    logic [3:0]        retire_pc_s;

    e203_exu_flush_prio #(.NCH(NCH)) u_prio (
        .req  (cmt_i_valid & cmt_i_flush),
        .hit  (win_hit_s),
        .idx  (win_idx_s),
        .mask (win_mask_s)
    );

    // Younger channels behind the winning flush are held off so they get squashed.
    always_comb begin
        if (state_r == ST_IDLE) begin
            ready_s = cmt_i_valid & win_mask_s;
        end else begin
            ready_s = '0;
        end
        acc_s         = cmt_i_valid & ready_s;
        nonflush_pc_s = popcount8(NCH_MAX'(acc_s & ~cmt_i_flush));
        retire_pc_s   = popcount8(NCH_MAX'(acc_s & cmt_i_retire));
    end

    // Operand mux for the winning channel.
    always_comb begin
        win_op1_s = '0;
        win_op2_s = '0;
        for (int i = 0; i < NCH; i++) begin
            win_op1_s = win_op1_s | ({PC_W{win_idx_s == SRC_W'(i)}} & cmt_i_op1[i*PC_W +: PC_W]);
            win_op2_s = win_op2_s | ({PC_W{win_idx_s == SRC_W'(i)}} & cmt_i_op2[i*PC_W +: PC_W]);
        end
    end

`ifdef E203_FLUSH_PC_EN
    logic [PC_W-1:0] pc_r;

    // Flush target is summed once at latch time so the IFU sees a ready-made PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= '0;
        end else if ((state_r == ST_IDLE) && win_hit_s) begin
            pc_r <= win_op1_s + win_op2_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pipe_flush_pc = pc_r;
`endif

    // Flush FSM with request, operand and gap-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            req_r     <= 1'b0;
            gap_cnt_r <= '0;
            op1_r     <= '0;
            op2_r     <= '0;
            src_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_hit_s) begin
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                        op1_r   <= win_op1_s;
                        op2_r   <= win_op2_s;
                        src_r   <= win_idx_s;
                    end else begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (pipe_flush_ack) begin
                        req_r <= 1'b0;
                        if (FLUSH_GAP > 0) begin
                            state_r   <= ST_GAP;
                            gap_cnt_r <= GAP_LOAD;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                    end
                end
                ST_GAP: begin
                    req_r <= 1'b0;
                    if (gap_cnt_r == '0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_r     <= 1'b0;
                    gap_cnt_r <= '0;
                end
            endcase
        end
    end

    // Retired-instruction counter; wraps freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= '0;
        end else begin
            instret_r <= instret_r + CNT_W'(retire_pc_s);
        end
    end

    assign cmt_i_ready        = ready_s;
    assign nonflush_cmt_cnt   = NCC_W'(nonflush_pc_s);
    assign pipe_flush_req     = req_r;
    assign pipe_flush_add_op1 = op1_r;
    assign pipe_flush_add_op2 = op2_r;
    assign pipe_flush_src     = src_r;
    assign flush_pulse        = req_r & pipe_flush_ack;
    assign instret_cnt        = instret_r;
    assign busy               = (state_r != ST_IDLE);

endmodule

// File: tb/tb_e203_exu_flush_ctrl.sv
// Self-checking bench: directed vector table, reset/wrap sequences, randomized run against a model.
module tb_e203_exu_flush_ctrl;
    import e203_flush_pkg::*;

    localparam int NCH = 2, PC_W = 32, CNT_W = 64, FLUSH_GAP = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]  valid = 2'b00, flush = 2'b00, retire = 2'b00;
    logic [1:0]  ready;
    logic [63:0] op1_bus = 64'd0, op2_bus = 64'd0;
    logic        req, ack = 1'b0, pulse, busy, src;
    logic [31:0] fop1, fop2;
    logic [1:0]  ncnt;
    logic [63:0] instret;
`ifdef E203_FLUSH_PC_EN
    logic [31:0] fpc;
`endif

    always #5 clk = ~clk;

    e203_exu_flush_ctrl #(.NCH(NCH), .PC_W(PC_W), .CNT_W(CNT_W), .FLUSH_GAP(FLUSH_GAP)) dut (
        .clk(clk), .rst(rst),
        .cmt_i_valid(valid), .cmt_i_ready(ready), .cmt_i_flush(flush), .cmt_i_retire(retire),
        .cmt_i_op1(op1_bus), .cmt_i_op2(op2_bus),
        .pipe_flush_req(req), .pipe_flush_ack(ack),
        .pipe_flush_add_op1(fop1), .pipe_flush_add_op2(fop2), .pipe_flush_src(src),
        .flush_pulse(pulse), .nonflush_cmt_cnt(ncnt), .instret_cnt(instret), .busy(busy)
`ifdef E203_FLUSH_PC_EN
        , .pipe_flush_pc(fpc)
`endif
    );

    e203_exu_flush_ctrl_chk #(.PC_W(PC_W), .SRC_W(1)) u_chk (
        .clk(clk), .rst(rst), .state(dut.state_r), .req(req), .ack(ack),
        .op1(fop1), .op2(fop2), .src(src)
    );

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0]  v, f, r;
        logic        ack;
        logic [31:0] a0, b0, a1, b1;
        logic [1:0]  e_rdy, e_cnt;
        logic        e_req, e_pulse, e_busy;
        logic [31:0] e_op1, e_op2;
        logic        e_src;
        logic [63:0] e_inst;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] v, f, r, input logic a,
                                input logic [31:0] a0, b0, a1, b1,
                                input logic [1:0] rdy, cnt, input logic rq, pl, bz,
                                input logic [31:0] eo1, eo2, input logic es, input logic [63:0] ei);
        vec_t x;
        x.v = v; x.f = f; x.r = r; x.ack = a;
        x.a0 = a0; x.b0 = b0; x.a1 = a1; x.b1 = b1;
        x.e_rdy = rdy; x.e_cnt = cnt; x.e_req = rq; x.e_pulse = pl; x.e_busy = bz;
        x.e_op1 = eo1; x.e_op2 = eo2; x.e_src = es; x.e_inst = ei;
        return x;
    endfunction

    vec_t tbl[16];

    // Reference model state for the randomized phase.
    bit          m_pend;
    int          m_quiet;
    logic [63:0] m_inst;
    logic [31:0] m_op1, m_op2;
    int          m_src;

    task automatic drive_zero();
        valid = 2'b00; flush = 2'b00; retire = 2'b00; ack = 1'b0;
        op1_bus = 64'd0; op2_bus = 64'd0;
    endtask

    task automatic model_cycle();
        logic [1:0] e_rdy;
        int w, nf, nr;
        e_rdy = 2'b00; w = -1; nf = 0; nr = 0;
        if (!m_pend && m_quiet == 0) begin
            for (int i = 0; i < NCH; i++) begin
                if (w < 0 && valid[i]) begin
                    e_rdy[i] = 1'b1;
                    if (!flush[i]) nf++;
                    if (retire[i]) nr++;
                    if (flush[i]) w = i;
                end
            end
        end
        chk("rnd_ready", {62'd0, ready}, {62'd0, e_rdy});
        chk("rnd_cnt", {62'd0, ncnt}, 64'(nf));
        chk("rnd_req", {63'd0, req}, {63'd0, m_pend});
        chk("rnd_pulse", {63'd0, pulse}, {63'd0, m_pend & ack});
        chk("rnd_busy", {63'd0, busy}, {63'd0, (m_pend || m_quiet > 0)});
        chk("rnd_instret", instret, m_inst);
        if (m_pend) begin
            chk("rnd_op1", {32'd0, fop1}, {32'd0, m_op1});
            chk("rnd_op2", {32'd0, fop2}, {32'd0, m_op2});
            chk("rnd_src", {63'd0, src}, 64'(m_src));
`ifdef E203_FLUSH_PC_EN
            chk("rnd_pc", {32'd0, fpc}, {32'd0, m_op1 + m_op2});
`endif
        end
        m_inst = m_inst + 64'(nr);
        if (!m_pend && m_quiet == 0) begin
            if (w >= 0) begin
                m_pend = 1'b1;
                m_op1  = op1_bus[w*32 +: 32];
                m_op2  = op2_bus[w*32 +: 32];
                m_src  = w;
            end
        end else if (m_pend) begin
            if (ack) begin
                m_pend  = 1'b0;
                m_quiet = FLUSH_GAP;
            end
        end else begin
            m_quiet--;
        end
    endtask

    initial begin
        // Directed table: no-flush streaming, young flush, old flush with held ack, gap.
        tbl[0]  = mk(2'b11,2'b00,2'b11,1'b0, 0,0,0,0,                2'b11,2'd2,0,0,0, 0,0,0, 64'd0);
        tbl[1]  = mk(2'b11,2'b00,2'b11,1'b0, 0,0,0,0,                2'b11,2'd2,0,0,0, 0,0,0, 64'd2);
        tbl[2]  = mk(2'b11,2'b00,2'b11,1'b0, 0,0,0,0,                2'b11,2'd2,0,0,0, 0,0,0, 64'd4);
        tbl[3]  = mk(2'b11,2'b10,2'b00,1'b0, 0,0,32'h8000_0000,32'h40, 2'b11,2'd1,0,0,0, 0,0,0, 64'd6);
        tbl[4]  = mk(2'b00,2'b00,2'b00,1'b0, 0,0,0,0,                2'b00,2'd0,1,0,1, 32'h8000_0000,32'h40,1, 64'd6);
        tbl[5]  = mk(2'b00,2'b00,2'b00,1'b1, 0,0,0,0,                2'b00,2'd0,1,1,1, 32'h8000_0000,32'h40,1, 64'd6);
        tbl[6]  = mk(2'b11,2'b00,2'b11,1'b0, 0,0,0,0,                2'b00,2'd0,0,0,1, 0,0,0, 64'd6);
        tbl[7]  = mk(2'b11,2'b11,2'b01,1'b0, 32'h100,32'h4,32'hDEAD,32'hBEEF, 2'b01,2'd0,0,0,0, 0,0,0, 64'd6);
        tbl[8]  = mk(2'b00,2'b00,2'b00,1'b0, 0,0,0,0,                2'b00,2'd0,1,0,1, 32'h100,32'h4,0, 64'd7);
        tbl[9]  = tbl[8];
        tbl[10] = tbl[8];
        tbl[11] = tbl[8];
        tbl[12] = mk(2'b00,2'b00,2'b00,1'b1, 0,0,0,0,                2'b00,2'd0,1,1,1, 32'h100,32'h4,0, 64'd7);
        tbl[13] = mk(2'b01,2'b00,2'b00,1'b0, 0,0,0,0,                2'b00,2'd0,0,0,1, 0,0,0, 64'd7);
        tbl[14] = mk(2'b01,2'b00,2'b01,1'b0, 0,0,0,0,                2'b01,2'd1,0,0,0, 0,0,0, 64'd7);
        tbl[15] = mk(2'b00,2'b00,2'b00,1'b0, 0,0,0,0,                2'b00,2'd0,0,0,0, 0,0,0, 64'd8);

        drive_zero();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        chk("rst_req", {63'd0, req}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ops", {fop1, fop2}, 64'd0);
        chk("rst_src", {63'd0, src}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            valid = tbl[i].v; flush = tbl[i].f; retire = tbl[i].r; ack = tbl[i].ack;
            op1_bus = {tbl[i].a1, tbl[i].a0};
            op2_bus = {tbl[i].b1, tbl[i].b0};
            @(negedge clk);
            n_vec++;
            chk($sformatf("v%0d_ready", i), {62'd0, ready}, {62'd0, tbl[i].e_rdy});
            chk($sformatf("v%0d_cnt", i), {62'd0, ncnt}, {62'd0, tbl[i].e_cnt});
            chk($sformatf("v%0d_req", i), {63'd0, req}, {63'd0, tbl[i].e_req});
            chk($sformatf("v%0d_pulse", i), {63'd0, pulse}, {63'd0, tbl[i].e_pulse});
            chk($sformatf("v%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].e_busy});
            chk($sformatf("v%0d_instret", i), instret, tbl[i].e_inst);
            if (tbl[i].e_req) begin
                chk($sformatf("v%0d_op1", i), {32'd0, fop1}, {32'd0, tbl[i].e_op1});
                chk($sformatf("v%0d_op2", i), {32'd0, fop2}, {32'd0, tbl[i].e_op2});
                chk($sformatf("v%0d_src", i), {63'd0, src}, {63'd0, tbl[i].e_src});
            end
        end

        // Async reset while a flush request is pending.
        @(posedge clk);
        #1 drive_zero(); valid = 2'b11; flush = 2'b01;
        @(posedge clk);
        #1 drive_zero();
        @(negedge clk);
        n_vec++;
        chk("rstreq_pre_req", {63'd0, req}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstreq_req", {63'd0, req}, 64'd0);
        chk("rstreq_instret", instret, 64'd0);
        chk("rstreq_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0; valid = 2'b01; flush = 2'b00; retire = 2'b00;
        @(negedge clk);
        n_vec++;
        chk("rstreq_ready", {62'd0, ready}, 64'd1);

        // Counter wrap from all ones.
        @(posedge clk);
        #1 valid = 2'b11; flush = 2'b00; retire = 2'b11;
        force dut.instret_r = {CNT_W{1'b1}};
        #1 release dut.instret_r;
        @(posedge clk);
        #1 drive_zero();
        @(negedge clk);
        n_vec++;
        chk("wrap_instret", instret, 64'd1);

        // Randomized run against the behavioural model.
        @(posedge clk);
        #1 rst = 1'b1; drive_zero();
        @(posedge clk);
        #1 rst = 1'b0;
        m_pend = 1'b0; m_quiet = 0; m_inst = 64'd0; m_op1 = 32'd0; m_op2 = 32'd0; m_src = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            valid   = 2'($urandom);
            flush   = 2'($urandom) & 2'($urandom);
            retire  = 2'($urandom);
            ack     = ($urandom_range(0, 2) == 0);
            op1_bus = {$urandom, $urandom};
            op2_bus = {$urandom, $urandom};
            @(negedge clk);
            n_vec++;
            model_cycle();
        end

`ifdef E203_FLUSH_PC_EN
        @(posedge clk);
        #1 rst = 1'b1; drive_zero();
        @(posedge clk);
        #1 rst = 1'b0; valid = 2'b01; flush = 2'b01;
        op1_bus = {32'd0, 32'hFFFF_FFF0}; op2_bus = {32'd0, 32'h20};
        @(posedge clk);
        #1 drive_zero();
        @(negedge clk);
        n_vec++;
        chk("pc_req", {63'd0, req}, 64'd1);
        chk("pc_value", {32'd0, fpc}, 64'h10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
